// File: rtl/tlk2711_pkg.sv
// Shared types and helpers for the TLK2711 receive buffer scheduler.
package tlk2711_pkg;

    localparam int MAX_BUF = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ALLOC = 3'd1,
        ST_RUN   = 3'd2,
        ST_STALL = 3'd3,
        ST_DRAIN = 3'd4
    } state_t;

    // A buffer count of 0 or beyond the instance size means "use every buffer".
    function automatic logic [3:0] clamp_buf_num(input logic [3:0] num, input int num_buf);
        if (num == 4'd0 || int'(num) > num_buf) begin
            return 4'(num_buf);
        end
        return num;
    endfunction

    function automatic logic [2:0] ring_next(input logic [2:0] idx, input logic [3:0] num);
        logic [3:0] nxt;
        nxt = {1'b0, idx} + 4'd1;
        return (nxt >= num) ? 3'd0 : nxt[2:0];
    endfunction

endpackage

// File: rtl/tlk2711_pulse_det.sv
// Rising-edge detector: one-cycle pulse on the first cycle a level goes high.
module tlk2711_pulse_det (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic d,
    output logic rise
);

    logic d_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_q <= 1'b0;
        end else if (clr) begin
            d_q <= 1'b0;
        end else begin
            d_q <= d;
        end
    end

    assign rise = d & ~d_q;

endmodule

// File: rtl/tlk2711_rx_buf_sched.sv
// Ring scheduler that arms the TLK2711 receiver into host-owned DDR buffers in strict order.
//   state | meaning
//   IDLE  | ring stopped, waiting for enable
//   ALLOC | check next buffer is free, arm link or stall
//   RUN   | link filling current buffer
//   STALL | next buffer still owned by host
//   DRAIN | enable dropped, finishing current buffer
module tlk2711_rx_buf_sched
    import tlk2711_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int NUM_BUF    = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_soft_rst,
    input  logic                  i_cfg_enable,
    input  logic [ADDR_WIDTH-1:0] i_cfg_base_addr,
    input  logic [31:0]           i_cfg_stride,
    input  logic [3:0]            i_cfg_buf_num,
    input  logic                  i_rx_interrupt,
    input  logic [31:0]           i_rx_total_packet,
    input  logic [15:0]           i_rx_body_num,
    input  logic                  i_loss_interrupt,
    output logic                  o_rx_start,
    output logic [ADDR_WIDTH-1:0] o_rx_base_addr,
    input  logic                  i_host_release,
    input  logic [2:0]            i_host_release_idx,
    output logic                  o_buf_irq,
    output logic [2:0]            o_buf_idx,
    output logic [31:0]           o_buf_len,
    output logic [15:0]           o_buf_frames,
    output logic                  o_err_irq,
    output logic                  o_overflow,
    output logic                  o_busy,
    output logic [MAX_BUF-1:0]    o_owned
);

    localparam int PW = (ADDR_WIDTH > 35) ? ADDR_WIDTH : 35;

    state_t                state, state_nxt;
    logic [2:0]            cur_idx;
    logic [3:0]            buf_num_q;
    logic [ADDR_WIDTH-1:0] base_q;
    logic [31:0]           stride_q;
    logic [MAX_BUF-1:0]    owned_nxt;
    logic [PW-1:0]         arm_off;
    logic [ADDR_WIDTH-1:0] arm_addr;
    logic                  rx_rise, rel_valid;
    logic                  start_ring, arm, stall, complete, err;

    tlk2711_pulse_det u_rx_det (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (i_soft_rst),
        .d    (i_rx_interrupt),
        .rise (rx_rise)
    );

    assign rel_valid = i_host_release && ({1'b0, i_host_release_idx} < buf_num_q)
                       && o_owned[i_host_release_idx];
    // Offset is formed wide enough for the full product, then wraps into the address space.
    assign arm_off  = PW'(stride_q) * PW'(cur_idx);
    assign arm_addr = base_q + arm_off[ADDR_WIDTH-1:0];
    assign o_busy   = (state != ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else if (i_soft_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        start_ring = 1'b0;
        arm        = 1'b0;
        stall      = 1'b0;
        complete   = 1'b0;
        err        = 1'b0;
        case (state)
            ST_IDLE: begin
                if (i_cfg_enable) begin
                    start_ring = 1'b1;
                    state_nxt  = ST_ALLOC;
                end
            end
            ST_ALLOC: begin
                if (!o_owned[cur_idx]) begin
                    arm       = 1'b1;
                    state_nxt = ST_RUN;
                end else begin
                    stall     = 1'b1;
                    state_nxt = ST_STALL;
                end
            end
            ST_RUN, ST_DRAIN: begin
                complete = rx_rise;
                err      = i_loss_interrupt;
                if (rx_rise || i_loss_interrupt) begin
                    state_nxt = (state == ST_RUN && i_cfg_enable) ? ST_ALLOC : ST_IDLE;
                end else if (state == ST_RUN && !i_cfg_enable) begin
                    state_nxt = ST_DRAIN;
                end
            end
            ST_STALL: begin
                // A release of the blocking buffer in this cycle unblocks immediately.
                if (!i_cfg_enable) begin
                    state_nxt = ST_IDLE;
                end else if (!o_owned[cur_idx] || (rel_valid && i_host_release_idx == cur_idx)) begin
                    state_nxt = ST_ALLOC;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        owned_nxt = o_owned;
        if (rel_valid) begin
            owned_nxt[i_host_release_idx] = 1'b0;
        end
        if (complete) begin
            owned_nxt[cur_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {o_rx_start, o_buf_irq, o_err_irq, o_overflow} <= '0;
            {o_rx_base_addr, base_q, stride_q}             <= '0;
            {o_buf_idx, o_buf_len, o_buf_frames}           <= '0;
            {o_owned, cur_idx, buf_num_q}                  <= '0;
        end else if (i_soft_rst) begin
            {o_rx_start, o_buf_irq, o_err_irq, o_overflow} <= '0;
            {o_rx_base_addr, base_q, stride_q}             <= '0;
            {o_buf_idx, o_buf_len, o_buf_frames}           <= '0;
            {o_owned, cur_idx, buf_num_q}                  <= '0;
        end else begin
            o_rx_start <= arm;
            o_buf_irq  <= complete;
            o_err_irq  <= err;
            o_owned    <= owned_nxt;
            if (start_ring) begin
                base_q     <= i_cfg_base_addr;
                stride_q   <= i_cfg_stride;
                buf_num_q  <= clamp_buf_num(i_cfg_buf_num, NUM_BUF);
                cur_idx    <= 3'd0;
                o_overflow <= 1'b0;
            end
            if (arm) begin
                o_rx_base_addr <= arm_addr;
            end
            if (stall) begin
                o_overflow <= 1'b1;
            end
            if (complete) begin
                o_buf_idx    <= cur_idx;
                o_buf_len    <= i_rx_total_packet;
                o_buf_frames <= i_rx_body_num;
                cur_idx      <= ring_next(cur_idx, buf_num_q);
            end
        end
    end

endmodule

// File: tb/tb_tlk2711_rx_buf_sched.sv
// Bench for the receive buffer scheduler: directed ring scenarios plus randomized traffic vs. a ring model.
module tb_tlk2711_rx_buf_sched;

    localparam int AW = 32;
    localparam int NB = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          i_soft_rst, i_cfg_enable;
    logic [AW-1:0] i_cfg_base_addr;
    logic [31:0]   i_cfg_stride;
    logic [3:0]    i_cfg_buf_num;
    logic          i_rx_interrupt;
    logic [31:0]   i_rx_total_packet;
    logic [15:0]   i_rx_body_num;
    logic          i_loss_interrupt;
    logic          o_rx_start;
    logic [AW-1:0] o_rx_base_addr;
    logic          i_host_release;
    logic [2:0]    i_host_release_idx;
    logic          o_buf_irq;
    logic [2:0]    o_buf_idx;
    logic [31:0]   o_buf_len;
    logic [15:0]   o_buf_frames;
    logic          o_err_irq, o_overflow, o_busy;
    logic [7:0]    o_owned;

    tlk2711_rx_buf_sched #(.ADDR_WIDTH(AW), .NUM_BUF(NB)) dut (
        .clk(clk), .rst_n(rst_n), .i_soft_rst(i_soft_rst), .i_cfg_enable(i_cfg_enable),
        .i_cfg_base_addr(i_cfg_base_addr), .i_cfg_stride(i_cfg_stride), .i_cfg_buf_num(i_cfg_buf_num),
        .i_rx_interrupt(i_rx_interrupt), .i_rx_total_packet(i_rx_total_packet),
        .i_rx_body_num(i_rx_body_num), .i_loss_interrupt(i_loss_interrupt),
        .o_rx_start(o_rx_start), .o_rx_base_addr(o_rx_base_addr),
        .i_host_release(i_host_release), .i_host_release_idx(i_host_release_idx),
        .o_buf_irq(o_buf_irq), .o_buf_idx(o_buf_idx), .o_buf_len(o_buf_len),
        .o_buf_frames(o_buf_frames), .o_err_irq(o_err_irq), .o_overflow(o_overflow),
        .o_busy(o_busy), .o_owned(o_owned)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit cmp_on = 0;

    logic [31:0] start_log[$];
    logic [2:0]  irq_log[$];
    int          err_cnt;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Ring model: which ring phase we are in, which buffers the host holds, where the ring points.
    localparam int M_IDLE = 0, M_ARM = 1, M_LIVE = 2, M_BLOCK = 3, M_DRAIN = 4;
    int          m_mode, m_idx, m_num;
    longint      m_base, m_stride;
    bit          m_own[8];
    bit          m_int_q, m_rise, m_rel_ok;
    logic        e_start, e_irq, e_err, e_ovf;
    logic [31:0] e_addr, e_len;
    logic [2:0]  e_idx;
    logic [15:0] e_frames;

    task model_clear;
        m_mode = M_IDLE; m_idx = 0; m_num = 0; m_base = 0; m_stride = 0; m_int_q = 0;
        foreach (m_own[i]) m_own[i] = 0;
        e_start = 0; e_irq = 0; e_err = 0; e_ovf = 0;
        e_addr = 0; e_len = 0; e_idx = 0; e_frames = 0;
    endtask

    function automatic logic [7:0] own_vec();
        logic [7:0] v;
        for (int i = 0; i < 8; i++) v[i] = m_own[i];
        return v;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n || i_soft_rst) begin
            model_clear();
        end else begin
            m_rise   = i_rx_interrupt && !m_int_q;
            m_int_q  = i_rx_interrupt;
            m_rel_ok = i_host_release && (int'(i_host_release_idx) < m_num) && m_own[i_host_release_idx];
            e_start = 0; e_irq = 0; e_err = 0;
            case (m_mode)
                M_IDLE: if (i_cfg_enable) begin
                    m_base   = longint'(i_cfg_base_addr);
                    m_stride = longint'(i_cfg_stride);
                    m_num    = (i_cfg_buf_num == 0 || int'(i_cfg_buf_num) > NB) ? NB : int'(i_cfg_buf_num);
                    m_idx    = 0;
                    e_ovf    = 0;
                    m_mode   = M_ARM;
                end
                M_ARM: if (!m_own[m_idx]) begin
                    e_start = 1;
                    e_addr  = 32'(m_base + longint'(m_idx) * m_stride);
                    m_mode  = M_LIVE;
                end else begin
                    e_ovf  = 1;
                    m_mode = M_BLOCK;
                end
                M_LIVE, M_DRAIN: if (m_rise || i_loss_interrupt) begin
                    e_err = i_loss_interrupt;
                    if (m_rise) begin
                        e_irq = 1; e_idx = 3'(m_idx); e_len = i_rx_total_packet; e_frames = i_rx_body_num;
                        m_own[m_idx] = 1;
                        m_idx = (m_idx + 1) % m_num;
                    end
                    m_mode = (m_mode == M_LIVE && i_cfg_enable) ? M_ARM : M_IDLE;
                end else if (m_mode == M_LIVE && !i_cfg_enable) begin
                    m_mode = M_DRAIN;
                end
                M_BLOCK: begin
                    if (!i_cfg_enable) m_mode = M_IDLE;
                    else if (!m_own[m_idx] || (m_rel_ok && int'(i_host_release_idx) == m_idx)) m_mode = M_ARM;
                end
                default: m_mode = M_IDLE;
            endcase
            if (m_rel_ok) m_own[i_host_release_idx] = 0;
        end
    end

    always @(negedge clk) begin
        if (rst_n && cmp_on) begin
            chk("rx_start", o_rx_start, e_start);
            chk("rx_base_addr", o_rx_base_addr, e_addr);
            chk("buf_irq", o_buf_irq, e_irq);
            chk("buf_idx", o_buf_idx, e_idx);
            chk("buf_len", o_buf_len, e_len);
            chk("buf_frames", o_buf_frames, e_frames);
            chk("err_irq", o_err_irq, e_err);
            chk("overflow", o_overflow, e_ovf);
            chk("busy", o_busy, m_mode != M_IDLE);
            chk("owned", o_owned, own_vec());
            if (o_rx_start) start_log.push_back(o_rx_base_addr);
            if (o_buf_irq)  irq_log.push_back(o_buf_idx);
            if (o_err_irq)  err_cnt++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic pulse_int();
        i_rx_interrupt = 1; tick(1); i_rx_interrupt = 0;
    endtask

    task automatic release_buf(input int idx);
        i_host_release = 1; i_host_release_idx = 3'(idx); tick(1); i_host_release = 0;
    endtask

    task automatic wait_starts(input int n, input int budget);
        int k = 0;
        while (start_log.size() < n && k < budget) begin tick(1); k++; end
        chk("wait_rx_start", start_log.size() >= n, 1);
    endtask

    task automatic clear_logs();
        start_log.delete(); irq_log.delete(); err_cnt = 0;
    endtask

    task automatic soft_reset();
        i_soft_rst = 1; tick(1); i_soft_rst = 0;
    endtask

    initial begin
        rst_n = 0; i_soft_rst = 0; i_cfg_enable = 0; i_cfg_base_addr = 0; i_cfg_stride = 0;
        i_cfg_buf_num = 0; i_rx_interrupt = 0; i_rx_total_packet = 0; i_rx_body_num = 0;
        i_loss_interrupt = 0; i_host_release = 0; i_host_release_idx = 0;
        clear_logs();
        tick(3);
        chk("reset_busy", o_busy, 0);
        chk("reset_owned", o_owned, 0);
        chk("reset_rx_start", o_rx_start, 0);
        chk("reset_addr", o_rx_base_addr, 0);
        chk("reset_buf_irq", o_buf_irq, 0);
        chk("reset_overflow", o_overflow, 0);
        rst_n = 1; cmp_on = 1;
        tick(2);

        // Three-buffer ring, no host release: fills, then stalls on buffer 0.
        i_cfg_base_addr = 32'h1000_0000; i_cfg_stride = 32'h4000; i_cfg_buf_num = 3;
        i_rx_total_packet = 32'd100; i_rx_body_num = 16'd2;
        i_cfg_enable = 1;
        wait_starts(1, 20);
        for (int k = 0; k < 3; k++) begin
            tick(3); pulse_int();
        end
        tick(8);
        chk("ring3_start_count", start_log.size(), 3);
        chk("ring3_addr0", start_log.size() > 0 ? start_log[0] : 32'hdead, 32'h1000_0000);
        chk("ring3_addr1", start_log.size() > 1 ? start_log[1] : 32'hdead, 32'h1000_4000);
        chk("ring3_addr2", start_log.size() > 2 ? start_log[2] : 32'hdead, 32'h1000_8000);
        for (int k = 0; k < 3; k++)
            chk("ring3_irq_idx", irq_log.size() > k ? irq_log[k] : 3'd7, 3'(k));
        chk("stall_overflow", o_overflow, 1);
        chk("stall_owned", o_owned, 8'h07);
        chk("stall_busy", o_busy, 1);
        i_host_release = 1; i_host_release_idx = 0; tick(1); i_host_release = 0;
        chk("unstall_no_start_yet", o_rx_start, 0);
        chk("unstall_owned", o_owned, 8'h06);
        tick(1);
        chk("unstall_start", o_rx_start, 1);
        chk("unstall_addr", o_rx_base_addr, 32'h1000_0000);

        // Soft reset mid-RUN, with an interrupt edge in the same cycle.
        tick(2);
        i_cfg_enable = 0; i_soft_rst = 1; i_rx_interrupt = 1; tick(1);
        i_soft_rst = 0; i_rx_interrupt = 0; tick(2);
        chk("soft_busy", o_busy, 0);
        chk("soft_owned", o_owned, 0);
        chk("soft_overflow", o_overflow, 0);
        chk("soft_no_irq", irq_log.size(), 3);

        // Loss on buffer 1 re-arms buffer 1.
        clear_logs();
        i_cfg_enable = 1;
        wait_starts(1, 20);
        tick(3); pulse_int();
        wait_starts(2, 10);
        tick(3);
        i_loss_interrupt = 1; tick(1); i_loss_interrupt = 0;
        wait_starts(3, 10);
        tick(4);
        chk("loss_err_pulses", err_cnt, 1);
        chk("loss_rearm_addr", start_log.size() > 2 ? start_log[2] : 32'hdead, 32'h1000_4000);
        chk("loss_no_irq", irq_log.size(), 1);
        release_buf(0);

        // Interrupt level held for 10 cycles completes once.
        tick(2);
        i_rx_total_packet = 32'd882; i_rx_body_num = 16'd1;
        i_rx_interrupt = 1; tick(10); i_rx_interrupt = 0;
        tick(3);
        chk("held_irq_count", irq_log.size(), 2);
        chk("held_len", o_buf_len, 32'd882);
        chk("held_frames", o_buf_frames, 16'd1);
        chk("held_idx", o_buf_idx, 3'd1);
        chk("held_next_addr", start_log.size() > 3 ? start_log[3] : 32'hdead, 32'h1000_8000);

        // Enable dropped mid-RUN: drain the armed buffer, then idle.
        tick(2);
        i_cfg_enable = 0; tick(3);
        chk("drain_busy", o_busy, 1);
        pulse_int(); tick(3);
        chk("drain_irq_count", irq_log.size(), 3);
        chk("drain_irq_idx", irq_log.size() > 2 ? irq_log[2] : 3'd7, 3'd2);
        chk("drain_idle", o_busy, 0);

        // Buffer count 0 clamps to the full ring of 4; out-of-range release ignored.
        soft_reset();
        clear_logs();
        i_cfg_buf_num = 0; i_cfg_enable = 1;
        wait_starts(1, 20);
        for (int k = 0; k < 4; k++) begin
            tick(3); pulse_int();
        end
        tick(8);
        chk("ring4_start_count", start_log.size(), 4);
        chk("ring4_addr3", start_log.size() > 3 ? start_log[3] : 32'hdead, 32'h1000_C000);
        chk("ring4_irq_idx3", irq_log.size() > 3 ? irq_log[3] : 3'd7, 3'd3);
        chk("ring4_owned", o_owned, 8'h0F);
        chk("ring4_overflow", o_overflow, 1);
        release_buf(6);
        tick(3);
        chk("release6_owned", o_owned, 8'h0F);
        chk("release6_no_start", start_log.size(), 4);

        // Randomized traffic against the ring model.
        soft_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc % 150 == 0) begin
                i_cfg_base_addr = $urandom;
                i_cfg_stride    = $urandom;
                i_cfg_buf_num   = 4'($urandom_range(0, 15));
            end
            if ($urandom_range(0, 63) == 0) i_cfg_enable = ~i_cfg_enable;
            i_rx_interrupt     = ($urandom_range(0, 3) == 0);
            i_loss_interrupt   = ($urandom_range(0, 40) == 0);
            i_host_release     = ($urandom_range(0, 2) == 0);
            i_host_release_idx = 3'($urandom_range(0, 7));
            i_soft_rst         = ($urandom_range(0, 400) == 0);
            i_rx_total_packet  = $urandom;
            i_rx_body_num      = 16'($urandom);
            tick(1);
        end
        i_rx_interrupt = 0; i_loss_interrupt = 0; i_host_release = 0; i_soft_rst = 0;
        tick(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tlk2711_rx_buf_sched.md
TLK2711_RX_BUF_SCHED -- requirements
Module: tlk2711_rx_buf_sched

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, DDR byte-address width.
REQ-002 SHALL have parameter NUM_BUF, default 4, number of ring buffers (legal 2..8).
REQ-003 SHALL have port clk, input, 1, single clock for all logic.
REQ-004 SHALL have port rst_n, input, 1, reset; asynchronous assertion, active-low.
REQ-005 SHALL have port i_soft_rst, input, 1, synchronous soft reset, active-high.
REQ-006 SHALL have port i_cfg_enable, input, 1, level; run ring while high.
REQ-007 SHALL have port i_cfg_base_addr, input, ADDR_WIDTH, byte address of buffer 0.
REQ-008 SHALL have port i_cfg_stride, input, 32, byte distance between buffers.
REQ-009 SHALL have port i_cfg_buf_num, input, 4, buffers in use.
REQ-010 SHALL have port i_rx_interrupt, input, 1, link "packet tail written" level.
REQ-011 SHALL have port i_rx_total_packet, input, 32, link byte count.
REQ-012 SHALL have port i_rx_body_num, input, 16, link frame count.
REQ-013 SHALL have port i_loss_interrupt, input, 1, link sync/link-loss pulse.
REQ-014 SHALL have port o_rx_start, output, 1, one-cycle arm pulse to link.
REQ-015 SHALL have port o_rx_base_addr, output, ADDR_WIDTH, address for armed buffer.
REQ-016 SHALL have port i_host_release, input, 1, host returns buffer (pulse).
REQ-017 SHALL have port i_host_release_idx, input, 3, index being returned.
REQ-018 SHALL have ports o_buf_irq (1), o_buf_idx (3), o_buf_len (32), o_buf_frames (16), outputs, completion pulse and its descriptor.
REQ-019 SHALL have ports o_err_irq (1), o_overflow (1, sticky), o_busy (1), o_owned (8, host-owned bitmap), outputs.

Function
REQ-020 FSM states SHALL be IDLE, ALLOC, RUN, STALL, DRAIN.
REQ-021 IDLE->ALLOC when i_cfg_enable=1; config sampled on this transition; cur_idx set to 0.
REQ-022 Sampled buf_num of 0 or >NUM_BUF SHALL be clamped to NUM_BUF.
REQ-023 ALLOC: if o_owned[cur_idx]=0, pulse o_rx_start one cycle, drive o_rx_base_addr = base + cur_idx*stride (truncated to ADDR_WIDTH, wraps), go RUN; else set o_overflow, go STALL.
REQ-024 o_rx_base_addr SHALL stay stable from the o_rx_start cycle until the next o_rx_start.
REQ-025 RUN: rising edge of i_rx_interrupt (i & ~i_q) SHALL, next cycle, pulse o_buf_irq with o_buf_idx=cur_idx, o_buf_len=i_rx_total_packet, o_buf_frames=i_rx_body_num (captured at the edge), set o_owned[cur_idx], advance cur_idx=(cur_idx+1) mod buf_num, go ALLOC (enable=1) or IDLE (enable=0).
REQ-026 Descriptor outputs SHALL hold until the next o_buf_irq.
REQ-027 RUN: i_loss_interrupt SHALL pulse o_err_irq next cycle and go ALLOC without advancing cur_idx (re-arm same buffer); if coincident with interrupt edge, completion wins, o_err_irq still pulses.
REQ-028 STALL: wait for o_owned[cur_idx]=0 (strict in-order ring), then ALLOC; enable=0 -> IDLE.
REQ-029 i_cfg_enable=0 in RUN SHALL go DRAIN; DRAIN behaves as RUN but exits to IDLE after completion or loss.
REQ-030 i_host_release SHALL clear o_owned[idx] next cycle; idx >= buf_num or not owned SHALL be ignored.
REQ-031 Release and completion same cycle: both applied; a release of a STALL-blocking index SHALL allow ALLOC on the following cycle.
REQ-032 o_overflow SHALL clear only on reset, soft reset, or IDLE->ALLOC.
REQ-033 o_busy SHALL be 1 in every state except IDLE.

Reset
REQ-034 rst_n low SHALL asynchronously force IDLE, cur_idx=0, o_owned=0, all outputs 0.
REQ-035 i_soft_rst SHALL have the same effect synchronously, including mid-RUN; no o_buf_irq for the aborted buffer.

Structure
REQ-036 State encoding and max-buffer constant (8) SHALL live in shared package tlk2711_pkg.
REQ-037 Rising-edge detection SHALL be one sub-module, tlk2711_pulse_det, instanced for i_rx_interrupt.

Verification
REQ-038 base=0x1000_0000, stride=0x4000, num=3, enable; three interrupt edges -> o_rx_start addrs 0x1000_0000, 0x1000_4000, 0x1000_8000, 0x1000_0000-blocked; o_buf_idx 0,1,2.
REQ-039 No host release after 3 completions, num=3 -> STALL, o_overflow=1, no o_rx_start; release idx 0 -> o_rx_start at 0x1000_0000 two cycles later.
REQ-040 i_loss_interrupt in RUN on idx 1 -> o_err_irq one pulse, re-start at idx 1 address, no o_buf_irq.
REQ-041 i_rx_interrupt held high 10 cycles with total=882, frames=1 -> exactly one o_buf_irq, o_buf_len=882, o_buf_frames=1.
REQ-042 Enable dropped mid-RUN -> DRAIN, completion still reported, then IDLE, o_busy=0; soft reset mid-RUN -> IDLE, o_owned=0, no irq.
REQ-043 i_cfg_buf_num=0 with NUM_BUF=4 -> ring of 4; release idx 6 -> ignored, o_owned unchanged.
